// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0/E1 prefix bytes into single key events
// and queues {ext, brk, code} in a first-word-fall-through FIFO for the CPU.
module ps2_key_event_ctrl #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 50000,
    parameter int PAUSE_LEN = 7
) (
    input  logic                     clk_50mhz,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic                     key_valid,
    output logic [7:0]               key_code,
    output logic                     key_ext,
    output logic                     key_brk,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int PC_W  = $clog2(PAUSE_LEN + 1);

    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [PC_W-1:0]  PC_LEN    = PC_W'(PAUSE_LEN);
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pcnt;
    logic [PC_W-1:0]    w_pcnt_nxt;
    logic [TO_W-1:0]    r_tcnt;
    logic               w_push;
    logic [9:0]         w_push_data;
    logic               w_err;
    logic               w_is_err;
    logic               w_is_prefix;
    logic               w_is_ignored;

    logic [9:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_proto_err;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;

    assign w_is_err     = (byte_in == 8'h00) || (byte_in == 8'hFF);
    assign w_is_prefix  = (byte_in == 8'hE0) || (byte_in == 8'hF0);
    assign w_is_ignored = (byte_in == 8'hAA) || (byte_in == 8'hFA) ||
                          (byte_in == 8'hFE) || (byte_in == 8'hEE);

    // Prefix decoder: next state, pause countdown, event push and error strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_push      = 1'b0;
        w_push_data = 10'd0;
        w_err       = 1'b0;
        if (byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (byte_in == 8'hF0) begin
                        w_state_nxt = S_BRK;
                    end else if (byte_in == 8'hE1) begin
                        w_state_nxt = S_PAUSE;
                        w_pcnt_nxt  = PC_LEN;
                    end else if (w_is_ignored) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_err) begin
                        w_err = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = {2'b00, byte_in};
                    end
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (byte_in == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (w_is_err) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = {2'b10, byte_in};
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (w_is_err) begin
                        w_err = 1'b1;
                    end else if (w_is_prefix) begin
                        w_push = 1'b0;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = {(r_state == S_EXT_BRK), 1'b1, byte_in};
                    end
                end
                S_PAUSE: begin
                    // The whole pause burst collapses into one E1 event on its last byte.
                    if (r_pcnt == PC_ONE) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b00, 8'hE1};
                        w_pcnt_nxt  = {PC_W{1'b0}};
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pcnt_nxt = r_pcnt - PC_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_pcnt_nxt  = {PC_W{1'b0}};
                end
            endcase
        end else if ((r_state != S_IDLE) && (r_tcnt == TO_LAST)) begin
            w_state_nxt = S_IDLE;
            w_pcnt_nxt  = {PC_W{1'b0}};
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Decoder state and pause countdown registers.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pcnt  <= {PC_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    // Inter-byte silence counter; only runs while a prefix is pending.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_tcnt <= {TO_W{1'b0}};
        end else if (byte_valid || (r_state == S_IDLE) || (r_tcnt == TO_LAST)) begin
            r_tcnt <= {TO_W{1'b0}};
        end else begin
            r_tcnt <= r_tcnt + TO_ONE;
        end
    end

    assign w_pop  = rd_en && (r_count != {CNT_W{1'b0}});
    assign w_full = (r_count == CNT_FULL);
    assign w_wr   = w_push && (!w_full || w_pop);

    // Event storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk_50mhz) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end else if (clr_err) begin
                r_proto_err <= 1'b0;
            end
        end
    end

    assign key_valid  = (r_count != {CNT_W{1'b0}});
    assign {key_ext, key_brk, key_code} = key_valid ? r_mem[r_rd_ptr] : 10'd0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based event model.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH     = 8;
    localparam int TIMEOUT   = 40;
    localparam int PAUSE_LEN = 7;

    logic       clk = 1'b0;
    logic       reset, byte_valid, rd_en, clr_err;
    logic [7:0] byte_in;
    logic       key_valid, key_ext, key_brk, overflow, proto_err;
    logic [7:0] key_code;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .PAUSE_LEN(PAUSE_LEN)) dut (
        .clk_50mhz (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_in   (byte_in),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_brk   (key_brk),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {ext,brk,code} events plus pending-prefix flags.
    logic [9:0] mq[$];
    bit m_ovf, m_perr, m_ext, m_brk;
    int m_pause, m_gap;

    typedef struct {
        logic        bv;
        logic [7:0]  b;
        logic        rd;
        logic        clr;
        logic [16:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic logic [16:0] mk(input logic kv, input logic ext, input logic brk,
                                       input logic [7:0] code, input logic [3:0] cnt,
                                       input logic ovf, input logic perr);
        return {kv, ext, brk, code, cnt, ovf, perr};
    endfunction

    function automatic vec_t v(input logic bv, input logic [7:0] b, input logic rd,
                               input logic clr, input logic [16:0] exp);
        vec_t r;
        r.bv = bv; r.b = b; r.rd = rd; r.clr = clr; r.exp = exp;
        return r;
    endfunction

    function automatic logic [16:0] model_out();
        if (mq.size() > 0)
            return mk(1'b1, mq[0][9], mq[0][8], mq[0][7:0], 4'(mq.size()), m_ovf, m_perr);
        return mk(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, m_ovf, m_perr);
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = {key_valid, key_ext, key_brk, key_code, fifo_count, overflow, proto_err};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got {kv,ext,brk,code,cnt,ovf,perr}=%h required %h",
                     name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic bv, input logic [7:0] b,
                              input logic rd, input logic clr);
        bit push, err;
        logic [9:0] ev;
        push = 1'b0; err = 1'b0; ev = 10'd0;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_perr = 0; m_ext = 0; m_brk = 0; m_pause = 0; m_gap = 0;
            return;
        end
        if (bv) begin
            m_gap = 0;
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin push = 1; ev = {2'b00, 8'hE1}; end
            end else if (m_brk) begin
                if (b == 8'h00 || b == 8'hFF) err = 1;
                else if (!(b == 8'hE0 || b == 8'hF0)) begin push = 1; ev = {m_ext, 1'b1, b}; end
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hE0) begin
                    if (b == 8'h00 || b == 8'hFF) err = 1;
                    else begin push = 1; ev = {2'b10, b}; end
                    m_ext = 0;
                end
            end else begin
                case (b)
                    8'hE0: m_ext = 1;
                    8'hF0: m_brk = 1;
                    8'hE1: m_pause = PAUSE_LEN;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
                    8'h00, 8'hFF: err = 1;
                    default: begin push = 1; ev = {2'b00, b}; end
                endcase
            end
        end else if (m_ext || m_brk || m_pause > 0) begin
            m_gap++;
            if (m_gap >= TIMEOUT) begin m_ext = 0; m_brk = 0; m_pause = 0; end
        end
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (clr) begin m_ovf = 0; m_perr = 0; end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
        end
        if (err) m_perr = 1;
    endtask

    task automatic cyc(input logic rst, input logic bv, input logic [7:0] b,
                       input logic rd, input logic clr);
        reset = rst; byte_valid = bv; byte_in = b; rd_en = rd; clr_err = clr;
        @(posedge clk);
        #1;
        model_step(rst, bv, b, rd, clr);
        check("model", model_out());
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0: return 8'hE0;
            1: return 8'hF0;
            2: return 8'hE1;
            3: return 8'h00;
            4: return 8'hFF;
            5: return 8'hAA;
            6: return 8'hFA;
            7: return 8'hFE;
            8: return 8'hEE;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [16:0] E;
        E = mk(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        tv.push_back(v(1'b0, 8'h00, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h1C, 1'b0, 1'b0, mk(1, 0, 0, 8'h1C, 4'd1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, E));
        tv.push_back(v(1'b1, 8'hF0, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h1C, 1'b0, 1'b0, mk(1, 0, 1, 8'h1C, 4'd1, 0, 0)));
        tv.push_back(v(1'b1, 8'hE0, 1'b0, 1'b0, mk(1, 0, 1, 8'h1C, 4'd1, 0, 0)));
        tv.push_back(v(1'b1, 8'hF0, 1'b0, 1'b0, mk(1, 0, 1, 8'h1C, 4'd1, 0, 0)));
        tv.push_back(v(1'b1, 8'h75, 1'b0, 1'b0, mk(1, 0, 1, 8'h1C, 4'd2, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, mk(1, 1, 1, 8'h75, 4'd1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, E));
        tv.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, E));
        tv.push_back(v(1'b1, 8'hAA, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'hFA, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 0, 0, 8'h00, 4'd0, 0, 1)));
        tv.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, E));
        tv.push_back(v(1'b1, 8'hFF, 1'b0, 1'b1, mk(0, 0, 0, 8'h00, 4'd0, 0, 1)));
        tv.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, E));
        tv.push_back(v(1'b1, 8'hE1, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h14, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h77, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'hE1, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'hF0, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h14, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'hF0, 1'b0, 1'b0, E));
        tv.push_back(v(1'b1, 8'h77, 1'b0, 1'b0, mk(1, 0, 0, 8'hE1, 4'd1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, E));

        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_state", E);

        foreach (tv[i]) begin
            cyc(1'b0, tv[i].bv, tv[i].b, tv[i].rd, tv[i].clr);
            check($sformatf("vec%0d", i), tv[i].exp);
        end

        // Overflow: DEPTH+1 makes with no reads, then push+pop while full.
        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
        check("ovf_full", mk(1, 0, 0, 8'h10, 4'd8, 1, 0));
        cyc(1'b0, 1'b1, 8'h30, 1'b1, 1'b0);
        check("ovf_push_pop", mk(1, 0, 0, 8'h11, 4'd8, 1, 0));
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("ovf_drained", mk(0, 0, 0, 8'h00, 4'd0, 1, 0));
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("ovf_clr", E);

        // Timeout abandons the E0 prefix; a shorter gap keeps it.
        send(8'hE0);
        idle(TIMEOUT);
        send(8'h1C);
        check("timeout_abandon", mk(1, 0, 0, 8'h1C, 4'd1, 0, 0));
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'hE0);
        idle(TIMEOUT - 3);
        send(8'h1C);
        check("timeout_kept", mk(1, 1, 0, 8'h1C, 4'd1, 0, 0));
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-prefix discards the prefix and queued events.
        send(8'h2C);
        send(8'hE0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_mid", E);
        send(8'h1C);
        check("reset_then_key", mk(1, 0, 0, 8'h1C, 4'd1, 0, 0));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            end else if ($urandom_range(0, 99) == 0) begin
                idle(TIMEOUT + 2);
            end else begin
                cyc(1'b0, ($urandom_range(0, 1) == 1), pick_byte(),
                    ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
